// File: rtl/game_pkg.sv
// Shared pad types: button word layout, illegal-byte mask and receiver states.
// Pure declarations; no logic, no latency, no flow control.
package game_pkg;

  typedef logic [6:0] btn_t;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_DEFEND = 5;
  localparam int BTN_SELECT = 6;

  parameter logic [7:0] PAD_ILLEGAL_MASK = 8'h80;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic logic pad_illegal(input logic [7:0] b);
    return |(b & PAD_ILLEGAL_MASK);
  endfunction

endpackage

// File: rtl/uart_rx_ch.sv
// One 8N1 pad channel: synchronizer, receiver FSM, byte decode and button hold timer.
// valid/err/btn update one cycle after the stop sample; no backpressure, bytes are never stalled.
module uart_rx_ch
  import game_pkg::*;
#(
  parameter int CLKS_PER_BIT = 28,
  parameter int HOLD_CYCLES  = 32256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic rx,
  output btn_t btn,
  output logic valid,
  output logic err,
  output logic sel_hit
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        sync;
  logic              rx_s;
  rx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [HOLD_W-1:0] hold_cnt;
  logic              stop_hit;
  logic              byte_ok;
  logic              byte_bad;

  assign rx_s = sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= 2'b11;
    else          sync <= {sync[0], rx};
  end

  // Decode happens on the stop-sample cycle; sel_hit is therefore one cycle ahead
  // of valid so the top can register o_start into the same cycle as valid.
  always_comb begin
    stop_hit = (state == RX_STOP) && (baud_cnt == BIT_LAST);
    byte_ok  = stop_hit && rx_s && !pad_illegal(shreg);
    byte_bad = stop_hit && (!rx_s || pad_illegal(shreg));
    sel_hit  = byte_ok && shreg[BTN_SELECT];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state    <= RX_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= RX_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? RX_IDLE : RX_BREAK;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // A byte landing on the expiry cycle wins over the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid    <= 1'b0;
      err      <= 1'b0;
      btn      <= '0;
      hold_cnt <= '0;
    end else begin
      valid <= byte_ok;
      err   <= byte_bad;
      if (byte_ok) begin
        btn      <= shreg[6:0];
        hold_cnt <= HOLD_LOAD;
      end else begin
        if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == '0 || hold_cnt == HOLD_W'(1)) btn <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_pad_hub.sv
// Multi-channel pad receiver hub: NUM_CH uart_rx_ch lanes plus arm flag and start priority encoder.
// o_start is registered in the same cycle as the winning o_valid; no backpressure.
module uart_pad_hub
  import game_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CLKS_PER_BIT = 28,
  parameter int HOLD_CYCLES  = 32256,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_CH-1:0]     i_rx,
  input  logic                  i_arm,
  output logic [NUM_CH*7-1:0]   o_btn,
  output logic [NUM_CH-1:0]     o_valid,
  output logic [NUM_CH-1:0]     o_err,
  output logic                  o_start,
  output logic [CH_W-1:0]       o_start_ch
);

  logic [NUM_CH-1:0] sel_hit;
  logic [CH_W-1:0]   first_ch;
  logic              armed;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    uart_rx_ch #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .rx     (i_rx[g]),
      .btn    (o_btn[7*g +: 7]),
      .valid  (o_valid[g]),
      .err    (o_err[g]),
      .sel_hit(sel_hit[g])
    );
  end

  // Lowest channel index wins when several select in the same cycle.
  always_comb begin
    first_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (sel_hit[c]) first_ch = CH_W'(c);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed      <= 1'b0;
      o_start    <= 1'b0;
      o_start_ch <= '0;
    end else begin
      o_start <= armed && (|sel_hit);
      if (armed && (|sel_hit)) o_start_ch <= first_ch;
      if (i_arm)         armed <= 1'b1;
      else if (|sel_hit) armed <= 1'b0;
    end
  end

endmodule
